// File: rtl/gpio_pkg.sv
// Shared encodings for the multi-core run sequencer: FSM state codes and LED drive levels.
package gpio_pkg;

  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] START_CORES   = 3'd1;
  localparam logic [2:0] WAIT_FOR_DONE = 3'd2;
  localparam logic [2:0] DONE_STATE    = 3'd3;
  localparam logic [2:0] ERROR_STATE   = 3'd4;
  localparam logic [2:0] SELFTEST      = 3'd5;

  localparam logic LED_OFF = 1'b0;
  localparam logic LED_ON  = 1'b1;

endpackage

// File: rtl/multicore_status_gpio_if.sv
// Board-side and core-side signals of the run sequencer; slave = sequencer, master = board/cores.
// Handshake: go and ack are level requests sampled on clk edges; core_start is a one-cycle pulse;
// core_done may be a pulse or a level and is latched sticky; state is a debug view of the FSM.
interface multicore_status_gpio_if #(
  parameter int NUM_CORES = 4
);
  logic                 go;
  logic                 ack;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_start;
  logic [NUM_CORES-1:0] led;
  logic                 led_done;
  logic                 busy;
  logic                 timeout;
  logic [2:0]           state;

  modport slave (
    input  go, ack, core_done,
    output core_start, led, led_done, busy, timeout, state
  );

  modport master (
    output go, ack, core_done,
    input  core_start, led, led_done, busy, timeout, state
  );
endinterface

// File: rtl/multicore_status_gpio_blink_divider.sv
// Free-running divider: blink is the counter MSB, step_tick pulses once every half blink period.
module blink_divider #(
  parameter int BLINK_DIV_W = 24
) (
  input  logic clk,
  input  logic rst,
  output logic blink,
  output logic step_tick
);
  logic [BLINK_DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign blink     = cnt[BLINK_DIV_W-1];
  assign step_tick = &cnt[BLINK_DIV_W-2:0];
endmodule

// File: rtl/multicore_status_gpio.sv
// Run sequencer and status-LED driver for NUM_CORES accelerator cores.
// Optional build macro LED_SELFTEST_EN adds a walking-one LED self-test after reset.
module multicore_status_gpio
  import gpio_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int BLINK_DIV_W    = 24,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input logic                     clk,
  input logic                     rst,
  multicore_status_gpio_if.slave  bus
);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] T_SAT  = TCW'(TIMEOUT_CYCLES);
  localparam logic [NUM_CORES-1:0] ALL_DONE = {NUM_CORES{1'b1}};
`ifdef LED_SELFTEST_EN
  localparam logic [2:0] RST_STATE = SELFTEST;
  localparam int SW = $clog2(NUM_CORES + 1);
`else
  localparam logic [2:0] RST_STATE = IDLE;
`endif

  logic [2:0]           state;
  logic [NUM_CORES-1:0] done_mask;
  logic [NUM_CORES-1:0] merged;
  logic [TCW-1:0]       tcnt;
  logic                 blink;
  logic                 step_tick;

  blink_divider #(.BLINK_DIV_W(BLINK_DIV_W)) u_blink (
    .clk       (clk),
    .rst       (rst),
    .blink     (blink),
    .step_tick (step_tick)
  );

  assign merged = done_mask | bus.core_done;

`ifdef LED_SELFTEST_EN
  logic [SW-1:0] step;

  always_ff @(posedge clk) begin
    if (rst)                                 step <= '0;
    else if (state == SELFTEST && step_tick) step <= step + 1'b1;
  end
`else
  logic unused_step_tick;
  assign unused_step_tick = step_tick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      done_mask <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.go) state <= START_CORES;
        START_CORES: begin
          done_mask <= bus.core_done;
          tcnt      <= '0;
          state     <= WAIT_FOR_DONE;
        end
        WAIT_FOR_DONE: begin
          done_mask <= merged;
          if (tcnt != T_SAT) tcnt <= tcnt + 1'b1;
          // All-done is checked first so a last done on the final cycle still succeeds.
          if (merged == ALL_DONE)  state <= DONE_STATE;
          else if (tcnt == T_LAST) state <= ERROR_STATE;
        end
        DONE_STATE, ERROR_STATE: begin
          if (bus.ack) begin
            state     <= IDLE;
            done_mask <= '0;
          end
        end
`ifdef LED_SELFTEST_EN
        SELFTEST: if (step_tick && int'(step) == NUM_CORES) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.core_start = '0;
    bus.led        = {NUM_CORES{LED_OFF}};
    bus.led_done   = LED_OFF;
    bus.busy       = 1'b0;
    bus.timeout    = 1'b0;
    bus.state      = state;
    case (state)
      START_CORES: begin
        bus.core_start = ALL_DONE;
        bus.led        = done_mask | {NUM_CORES{blink}};
        bus.busy       = 1'b1;
      end
      WAIT_FOR_DONE: begin
        bus.led  = done_mask | {NUM_CORES{blink}};
        bus.busy = 1'b1;
      end
      DONE_STATE: begin
        bus.led      = {NUM_CORES{LED_ON}};
        bus.led_done = LED_ON;
      end
      ERROR_STATE: begin
        // Cores that never reported stay dark so the hung ones are visible.
        bus.led      = done_mask;
        bus.led_done = blink;
        bus.timeout  = 1'b1;
      end
`ifdef LED_SELFTEST_EN
      SELFTEST: begin
        for (int i = 0; i < NUM_CORES; i++) bus.led[i] = (int'(step) == i);
        bus.led_done = (int'(step) == NUM_CORES);
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: doc/multicore_status_gpio.md
Name: multicore_status_gpio

Overview:
Parametrised run-sequencer and status-LED driver for the multi-core accelerator.
- Launches NUM_CORES cores with a one-cycle start pulse and collects their done indications.
- Drives one LED per core plus a done LED: blinking while a core runs, solid when it finishes.
- Adds a watchdog timeout with an error state, and an acknowledge to return to idle.
- Sits between the board GPIO pins and the core array's start/done lines.

Parameters:
- NUM_CORES, 4, number of cores/LED channels (1..32).
- BLINK_DIV_W, 24, blink counter width; blink bit = counter MSB, period 2^BLINK_DIV_W cycles.
- TIMEOUT_CYCLES, 100000000, cycles allowed in WAIT_FOR_DONE before error (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- go  in  1  run request; sampled only in IDLE
- ack  in  1  return-to-idle request; sampled only in DONE_STATE/ERROR_STATE
- core_done  in  NUM_CORES  per-core done, pulse or level; latched sticky
- core_start  out  NUM_CORES  start pulse to all cores
- led  out  NUM_CORES  per-core status LED
- led_done  out  1  run-complete / error LED
- busy  out  1  high in START_CORES and WAIT_FOR_DONE
- timeout  out  1  high in ERROR_STATE

Behaviour:
- All outputs are Moore-decoded from registered state, done_mask and the blink bit. There is no combinational path from any input to any output.

Reset:
- While rst=1: state=IDLE (or SELFTEST, see the optional feature); done_mask=0; timeout counter=0; blink counter=0.
- All outputs are 0 in the cycle after rst is sampled high.
- Reset mid-run aborts immediately. No core_start is issued, and already-latched done bits are discarded.

State transitions:
- IDLE: go=1 -> START_CORES.
- START_CORES: lasts exactly 1 cycle; core_start = all ones for that cycle. Clears the timeout counter and sets done_mask <= core_done, so a done arriving this cycle is kept. -> WAIT_FOR_DONE.
- WAIT_FOR_DONE: each cycle, done_mask <= done_mask | core_done, and the counter increments.
  - If (done_mask | core_done) is all ones -> DONE_STATE.
  - Else if counter == TIMEOUT_CYCLES-1 -> ERROR_STATE.
  - All-done wins over timeout in the same cycle.
- DONE_STATE: ack=1 -> IDLE (done_mask cleared). go is ignored.
- ERROR_STATE: ack=1 -> IDLE (done_mask cleared). go is ignored.
- go outside IDLE and ack outside DONE/ERROR have no effect.
- go and ack together in IDLE: go is taken.

LED decode:
- IDLE: led=0, led_done=0.
- START/WAIT: led[i] = done_mask[i] ? 1 : blink; led_done=0.
- DONE_STATE: led = all ones, led_done=1.
- ERROR_STATE: led[i] = done_mask[i], so hung cores are dark; led_done=blink.

Counters:
- Blink counter: free-running, wraps modulo 2^BLINK_DIV_W.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

Latency:
- go to core_start: 1 cycle.
- Last core_done to DONE_STATE and led_done: 1 cycle.

Optional Feature:
- Macro LED_SELFTEST_EN.
- Defined: rst enters SELFTEST instead of IDLE. A walking one steps across led[0]..led[NUM_CORES-1], then led_done.
  - Each step lasts 2^(BLINK_DIV_W-1) cycles.
  - After the led_done step -> IDLE. go and ack are ignored during SELFTEST.
  - busy=0 during SELFTEST.
- Undefined: SELFTEST state and step logic are absent; reset goes directly to IDLE.

Decomposition:
- Shared package gpio_pkg holds the state encoding localparams (3-bit):
  - IDLE=0, START_CORES=1, WAIT_FOR_DONE=2, DONE_STATE=3, ERROR_STATE=4, SELFTEST=5.
- The LED decode constants also live in gpio_pkg.
- One sub-module, blink_divider: free-running counter with outputs blink (MSB) and step_tick (pulse every 2^(BLINK_DIV_W-1) cycles).
- The FSM, done_mask and timeout counter stay in the top module.

Test Plan:
Bench settings: NUM_CORES=4, BLINK_DIV_W=4, TIMEOUT_CYCLES=50.
1. Reset, then go pulse at cycle 5 -> core_start=4'b1111 exactly at cycle 6 only; busy=1 from cycle 6.
2. core_done pulses on cores 2, 0, 3, 1 at WAIT cycles 3, 7, 9, 12 -> each led[i] goes from blinking (period 16) to solid on the following cycle. DONE_STATE and led_done=1 one cycle after the core-1 pulse; busy=0.
3. Cores 0, 1, 3 done; core 2 never -> ERROR_STATE 50 cycles after entering WAIT. timeout=1, led=4'b1011, led_done toggles every 8 cycles. ack -> IDLE, all LEDs 0.
4. Final core_done in the same cycle the counter reaches 49 -> DONE_STATE, not ERROR_STATE.
5. rst asserted mid-WAIT with done_mask=4'b0101 -> next cycle all outputs 0, IDLE. A later go restarts with done_mask cleared.
6. With LED_SELFTEST_EN: after reset, led[0]..led[3] then led_done each high for 8 cycles, go ignored throughout. IDLE at cycle 40.
